// File: rtl/uart_pkg.sv
// Shared UART register-lane layout, start-bit value and arbiter state encoding.
// Pure definitions: no latency, no flow control.
package uart_pkg;

   localparam int CTRL_LANE   = 3;
   localparam int WDATA_LANE  = 2;
   localparam int RDATA_LANE  = 1;
   localparam int STATUS_LANE = 0;

   localparam logic [7:0] START_BIT = 8'h01;

   // A transmit write touches only the control and write-data lanes.
   localparam logic [3:0] TX_BYTE_MASK = 4'((1 << CTRL_LANE) | (1 << WDATA_LANE));

   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_WRITE     = 2'd1,
      ST_WAIT_BUSY = 2'd2,
      ST_WAIT_IDLE = 2'd3
   } arb_state_t;

   function automatic logic [31:0] tx_word(input logic [7:0] tx_byte);
      tx_word = (32'(START_BIT) << (8 * CTRL_LANE)) | (32'(tx_byte) << (8 * WDATA_LANE));
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, history advances on an accepted grant.
// Zero latency; a tie goes to whoever was not granted last.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] valid,
   input  logic       advance,
   output logic [1:0] grant_onehot,
   output logic       grant_id
);

   logic r_last_grant;

   always_comb begin
      grant_onehot = 2'b00;
      case (valid)
         2'b01:   grant_onehot = 2'b01;
         2'b10:   grant_onehot = 2'b10;
         2'b11:   grant_onehot = r_last_grant ? 2'b01 : 2'b10;
         default: grant_onehot = 2'b00;
      endcase
   end

   assign grant_id = grant_onehot[1];

   // Starts at 1 so requester 0 wins the first tie after reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_last_grant <= 1'b1;
      end else if (advance && (|valid)) begin
         r_last_grant <= grant_id;
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one memory-mapped UART between console and trace requesters, one byte per grant.
// Grant pulse in IDLE, write strobe the next cycle; no new grant until the UART reports idle.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter logic [31:0] UART_BASE    = 32'hFFFF_FFF4,
   parameter int          BUSY_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  req_valid,
   input  logic [7:0]  req_data0,
   input  logic [7:0]  req_data1,
   output logic [1:0]  req_ready,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_write,
   output logic [3:0]  byte_mask,
   input  logic [31:0] mem_read_data,
   output logic        busy,
   output logic        grant_id,
   output logic        timeout_err,
   input  logic        err_clr
);

   localparam int               CNT_W    = $clog2(BUSY_TIMEOUT) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;

   arb_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_mem_write;
   logic [3:0]       r_byte_mask;
   logic [31:0]      r_wdata;
   logic             r_grant_id;
   logic             r_timeout_err;

   logic [1:0] w_grant_onehot;
   logic       w_arb_id;
   logic       w_take;
   logic [7:0] w_tx_byte;
   logic       w_status_busy;
   logic       w_unused_rd;

   // Ready is gated by reset so a held request cannot be acknowledged while in reset.
   assign w_take        = reset_n && (r_state == ST_IDLE) && (|req_valid);
   assign w_tx_byte     = w_arb_id ? req_data1 : req_data0;
   assign w_status_busy = mem_read_data[8 * STATUS_LANE];
   assign w_unused_rd   = ^{mem_read_data[31:8 * RDATA_LANE], mem_read_data[8 * RDATA_LANE - 1:1]};

   rr_arb2 u_arb (
      .clk          (clk),
      .reset_n      (reset_n),
      .valid        (req_valid),
      .advance      (w_take),
      .grant_onehot (w_grant_onehot),
      .grant_id     (w_arb_id)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state       <= ST_IDLE;
         r_cnt         <= '0;
         r_mem_write   <= 1'b0;
         r_byte_mask   <= 4'b0000;
         r_wdata       <= 32'h0;
         r_grant_id    <= 1'b0;
         r_timeout_err <= 1'b0;
      end else begin
         // A timeout set later in this block overrides a same-cycle clear.
         if (err_clr) begin
            r_timeout_err <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_take) begin
                  r_state     <= ST_WRITE;
                  r_grant_id  <= w_arb_id;
                  r_mem_write <= 1'b1;
                  r_byte_mask <= TX_BYTE_MASK;
                  r_wdata     <= tx_word(w_tx_byte);
               end
            end
            ST_WRITE: begin
               r_state     <= ST_WAIT_BUSY;
               r_cnt       <= '0;
               r_mem_write <= 1'b0;
               r_byte_mask <= 4'b0000;
               r_wdata     <= 32'h0;
            end
            ST_WAIT_BUSY: begin
               if (w_status_busy) begin
                  r_state <= ST_WAIT_IDLE;
               end else if (r_cnt == CNT_LAST) begin
                  r_timeout_err <= 1'b1;
                  r_state       <= ST_IDLE;
               end else if (r_cnt != CNT_MAX) begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_WAIT_IDLE: begin
               if (!w_status_busy) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign req_ready      = w_take ? w_grant_onehot : 2'b00;
   assign mem_address    = UART_BASE;
   assign mem_write      = r_mem_write;
   assign byte_mask      = r_byte_mask;
   assign mem_write_data = r_wdata;
   assign busy           = (r_state != ST_IDLE);
   assign grant_id       = r_grant_id;
   assign timeout_err    = r_timeout_err;

endmodule
